// File: rtl/peripheral_wb_burst_ram.sv
// Wishbone B3 slave RAM: classic and registered-feedback bursts (constant, linear, wrap-4/8/16),
// registered ack/err/data and per-beat read/write strobes for the monitoring side.
module peripheral_wb_burst_ram #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic [1:0]  bte_i,
    input  logic [2:0]  cti_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    output logic        ack_o,
    output logic        err_o,
    output logic [31:0] dat_o,
    output logic        sig_read,
    output logic        sig_write
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned BW = AW + 2;

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_burst_adr;
    logic [31:0]     r_mem [MEM_DEPTH];

    logic            w_in_range;
    logic [AW-1:0]   w_index;
    logic            w_wr_en;
    logic            w_cont;
    logic            w_overflow;
    logic [AW-1:0]   w_next_adr;
    logic [31:0]     w_wr_data;
    logic [31:0]     w_rd_next;

    // Base alignment lets the range test collapse to an upper-bit compare.
    assign w_in_range = (adr_i[31:BW] == BASE_ADDR[31:BW]) && (adr_i[1:0] == 2'b00);
    assign w_index    = adr_i[BW-1:2];
    assign w_wr_en    = cyc_i & stb_i & ack_o & we_i & rst;
    assign w_cont     = (cti_i == 3'b001) || (cti_i == 3'b010);

    // Next burst word; wrap modes only advance the low bits of the index.
    always_comb begin
        w_next_adr = r_burst_adr;
        w_overflow = 1'b0;
        if (cti_i == 3'b010) begin
            case (bte_i)
                2'b00: begin
                    w_next_adr = r_burst_adr + AW'(1);
                    w_overflow = &r_burst_adr;
                end
                2'b01:   w_next_adr[1:0] = r_burst_adr[1:0] + 2'd1;
                2'b10:   w_next_adr[2:0] = r_burst_adr[2:0] + 3'd1;
                default: w_next_adr[3:0] = r_burst_adr[3:0] + 4'd1;
            endcase
        end
    end

    // Write-first forwarding when the next beat reads the word being written.
    always_comb begin
        w_wr_data = r_mem[r_burst_adr];
        for (int b = 0; b < 4; b++) begin
            if (sel_i[b]) begin
                w_wr_data[8*b +: 8] = dat_i[8*b +: 8];
            end
        end
        w_rd_next = (w_wr_en && (w_next_adr == r_burst_adr)) ? w_wr_data : r_mem[w_next_adr];
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_i[b]) begin
                    r_mem[r_burst_adr][8*b +: 8] <= dat_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_burst_adr <= '0;
            ack_o       <= 1'b0;
            err_o       <= 1'b0;
            dat_o       <= 32'h0;
            sig_read    <= 1'b0;
            sig_write   <= 1'b0;
        end else begin
            sig_read  <= 1'b0;
            sig_write <= 1'b0;
            if (!cyc_i) begin
                r_state <= S_IDLE;
                ack_o   <= 1'b0;
                err_o   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // A raised err terminates on this edge; new requests wait one cycle.
                        if (err_o) begin
                            err_o <= 1'b0;
                        end else if (stb_i) begin
                            if (w_in_range) begin
                                ack_o       <= 1'b1;
                                dat_o       <= r_mem[w_index];
                                r_burst_adr <= w_index;
                                r_state     <= S_ACTIVE;
                            end else begin
                                err_o <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (!stb_i) begin
                            ack_o   <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            sig_write <= we_i;
                            sig_read  <= ~we_i;
                            if (w_cont && !w_overflow) begin
                                r_burst_adr <= w_next_adr;
                                dat_o       <= w_rd_next;
                            end else begin
                                ack_o   <= 1'b0;
                                err_o   <= w_cont;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule
